// File: rtl/mant_mul_seq.sv
// Sequential MANT_W x MANT_W mantissa multiplier: four half-width partial products
// are issued to one shared multiplier and accumulated once its pipeline delivers them.
module mant_mul_seq #(
  parameter int unsigned MANT_W  = 24,
  parameter int unsigned MUL_W   = 18,
  parameter int unsigned MUL_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [MANT_W-1:0]     a,
  input  logic [MANT_W-1:0]     b,
  output logic                  busy,
  output logic                  done,
  output logic [2*MANT_W-1:0]   product,
  output logic [MUL_W-1:0]      mul_a,
  output logic [MUL_W-1:0]      mul_b,
  input  logic [2*MUL_W-1:0]    mul_p
);

  localparam int unsigned HALF  = MANT_W / 2;
  localparam int unsigned PP_W  = 2 * HALF;
  localparam int unsigned ACC_W = 2 * MANT_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t              r_state;
  logic [1:0]          r_k;
  logic [MANT_W-1:0]   r_a;
  logic [MANT_W-1:0]   r_b;
  logic [ACC_W-1:0]    r_acc;
  logic [ACC_W-1:0]    r_product;
  logic [MUL_W-1:0]    r_mul_a;
  logic [MUL_W-1:0]    r_mul_b;
  logic                r_busy;
  logic                r_done;
  logic                r_tag_v [MUL_LAT];
  logic [1:0]          r_tag_k [MUL_LAT];

  state_t              w_state_nx;
  logic [1:0]          w_k_nx;
  logic [MANT_W-1:0]   w_a_nx;
  logic [MANT_W-1:0]   w_b_nx;
  logic [ACC_W-1:0]    w_acc_nx;
  logic [ACC_W-1:0]    w_product_nx;
  logic [MUL_W-1:0]    w_mul_a_nx;
  logic [MUL_W-1:0]    w_mul_b_nx;
  logic                w_busy_nx;
  logic                w_done_nx;
  logic                w_push_v;
  logic [1:0]          w_push_k;
  logic                w_tag_v;
  logic [1:0]          w_tag_k;
  logic [PP_W-1:0]     w_pp;
  logic [ACC_W-1:0]    w_term;
  logic [HALF-1:0]     w_half_a;
  logic [HALF-1:0]     w_half_b;

  assign w_tag_v = r_tag_v[MUL_LAT-1];
  assign w_tag_k = r_tag_k[MUL_LAT-1];
  assign w_pp    = mul_p[PP_W-1:0];

  // Upper multiplier output bits cannot be non-zero for half-width operands.
  if (MUL_W > HALF) begin : g_mul_p_hi
    logic w_unused_mul_p;
    assign w_unused_mul_p = ^mul_p[2*MUL_W-1:PP_W];
  end

  // k[1] picks the A half, k[0] picks the B half: (L,L) (L,H) (H,L) (H,H).
  assign w_half_a = r_k[1] ? r_a[MANT_W-1:HALF] : r_a[HALF-1:0];
  assign w_half_b = r_k[0] ? r_b[MANT_W-1:HALF] : r_b[HALF-1:0];

  always_comb begin
    w_term = ACC_W'(w_pp);
    unique case (w_tag_k)
      2'd0:    w_term = ACC_W'(w_pp);
      2'd3:    w_term = ACC_W'(w_pp) << PP_W;
      default: w_term = ACC_W'(w_pp) << HALF;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    w_state_nx   = r_state;
    w_k_nx       = r_k;
    w_a_nx       = r_a;
    w_b_nx       = r_b;
    w_acc_nx     = r_acc;
    w_product_nx = r_product;
    w_mul_a_nx   = '0;
    w_mul_b_nx   = '0;
    w_busy_nx    = r_busy;
    w_done_nx    = 1'b0;
    w_push_v     = 1'b0;
    w_push_k     = r_k;

    if (w_tag_v) begin
      w_acc_nx = r_acc + w_term;
    end

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_a_nx     = a;
          w_b_nx     = b;
          w_acc_nx   = '0;
          w_k_nx     = 2'd0;
          w_busy_nx  = 1'b1;
          w_state_nx = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_mul_a_nx = MUL_W'(w_half_a);
        w_mul_b_nx = MUL_W'(w_half_b);
        w_push_v   = 1'b1;
        w_push_k   = r_k;
        w_k_nx     = 2'(r_k + 2'd1);
        if (r_k == 2'd3) begin
          w_state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_tag_v && (w_tag_k == 2'd3)) begin
          w_product_nx = r_acc + w_term;
          w_done_nx    = 1'b1;
          w_busy_nx    = 1'b0;
          w_state_nx   = S_IDLE;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_k       <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_product <= '0;
      r_mul_a   <= '0;
      r_mul_b   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      for (int i = 0; i < int'(MUL_LAT); i++) begin
        r_tag_v[i] <= 1'b0;
        r_tag_k[i] <= '0;
      end
    end else begin
      r_state   <= w_state_nx;
      r_k       <= w_k_nx;
      r_a       <= w_a_nx;
      r_b       <= w_b_nx;
      r_acc     <= w_acc_nx;
      r_product <= w_product_nx;
      r_mul_a   <= w_mul_a_nx;
      r_mul_b   <= w_mul_b_nx;
      r_busy    <= w_busy_nx;
      r_done    <= w_done_nx;
      // Tag pipeline mirrors the multiplier latency so each mul_p is paired with its k.
      r_tag_v[0] <= w_push_v;
      r_tag_k[0] <= w_push_k;
      for (int i = 1; i < int'(MUL_LAT); i++) begin
        r_tag_v[i] <= r_tag_v[i-1];
        r_tag_k[i] <= r_tag_k[i-1];
      end
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;
  assign mul_a   = r_mul_a;
  assign mul_b   = r_mul_b;

endmodule

// File: tb/tb_mant_mul_seq.sv
// Bench for mant_mul_seq: three instances (MUL_LAT 1, 2, 4) share stimulus and are
// checked every cycle against a transaction-level timing/arithmetic model.
module tb_mant_mul_seq;

  localparam int NL = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [23:0] a;
  logic [23:0] b;
  logic [11:0] junk;

  logic        busy_w    [NL];
  logic        done_w    [NL];
  logic [47:0] product_w [NL];
  logic [17:0] mul_a_w   [NL];
  logic [17:0] mul_b_w   [NL];
  logic [35:0] mul_p_w   [NL];

  logic        exp_busy  [NL];
  logic        exp_done  [NL];
  logic [47:0] exp_prod  [NL];
  logic [17:0] exp_ma    [NL];
  logic [17:0] exp_mb    [NL];

  int errors = 0;
  int checks = 0;
  bit run_chk = 1'b0;

  always #5 clk = ~clk;

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 2 : 4);
  endfunction

  // DUT plus a behavioural shared multiplier with latency L and junk in unused high bits.
  for (genvar g = 0; g < NL; g++) begin : g_lane
    localparam int unsigned L = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    logic [35:0] full;
    logic [35:0] raw;
    assign full = 36'(mul_a_w[g]) * 36'(mul_b_w[g]);
    assign raw  = {junk, full[23:0]};

    if (L == 1) begin : g_comb
      assign mul_p_w[g] = raw;
    end else begin : g_pipe
      logic [35:0] pipe [L-1];
      always @(posedge clk) begin
        pipe[0] <= raw;
        for (int i = 1; i < int'(L) - 1; i++) pipe[i] <= pipe[i-1];
      end
      assign mul_p_w[g] = pipe[L-2];
    end

    mant_mul_seq #(.MANT_W(24), .MUL_W(18), .MUL_LAT(L)) u_dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy_w[g]),
      .done    (done_w[g]),
      .product (product_w[g]),
      .mul_a   (mul_a_w[g]),
      .mul_b   (mul_b_w[g]),
      .mul_p   (mul_p_w[g])
    );
  end

  initial forever begin
    @(negedge clk);
    junk = 12'($urandom);
  end

  // Transaction model: accept at edge t0, pair k issued at t0+1+k, result at t0+4+L.
  int          m_n;
  int          m_t0  [NL];
  bit          m_act [NL];
  logic [23:0] m_a   [NL];
  logic [23:0] m_b   [NL];

  initial begin
    m_n = 0;
    for (int g = 0; g < NL; g++) begin
      m_act[g] = 1'b0; m_t0[g] = 0; m_a[g] = '0; m_b[g] = '0;
      exp_busy[g] = 1'b0; exp_done[g] = 1'b0; exp_prod[g] = '0;
      exp_ma[g] = '0; exp_mb[g] = '0;
    end
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_n = 0;
        for (int g = 0; g < NL; g++) begin
          m_act[g] = 1'b0;
          exp_busy[g] = 1'b0; exp_done[g] = 1'b0; exp_prod[g] = '0;
          exp_ma[g] = '0; exp_mb[g] = '0;
        end
      end else begin
        m_n++;
        for (int g = 0; g < NL; g++) begin
          int k;
          exp_done[g] = 1'b0;
          if (m_act[g] && (m_n == m_t0[g] + 4 + lat_of(g))) begin
            m_act[g]    = 1'b0;
            exp_done[g] = 1'b1;
            exp_prod[g] = 48'(m_a[g]) * 48'(m_b[g]);
          end else if (!m_act[g] && start) begin
            m_act[g] = 1'b1;
            m_t0[g]  = m_n;
            m_a[g]   = a;
            m_b[g]   = b;
          end
          exp_busy[g] = m_act[g];
          k = m_n - m_t0[g] - 1;
          if (m_act[g] && k >= 0 && k <= 3) begin
            exp_ma[g] = 18'((k >= 2) ? m_a[g][23:12] : m_a[g][11:0]);
            exp_mb[g] = 18'((k % 2 == 1) ? m_b[g][23:12] : m_b[g][11:0]);
          end else begin
            exp_ma[g] = '0;
            exp_mb[g] = '0;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every lane against the model.
  initial forever begin
    @(negedge clk);
    if (run_chk) begin
      for (int g = 0; g < NL; g++) begin
        chk($sformatf("busy_l%0d", g),    64'(busy_w[g]),    64'(exp_busy[g]));
        chk($sformatf("done_l%0d", g),    64'(done_w[g]),    64'(exp_done[g]));
        chk($sformatf("product_l%0d", g), 64'(product_w[g]), 64'(exp_prod[g]));
        chk($sformatf("mul_a_l%0d", g),   64'(mul_a_w[g]),   64'(exp_ma[g]));
        chk($sformatf("mul_b_l%0d", g),   64'(mul_b_w[g]),   64'(exp_mb[g]));
      end
    end
  end

  task automatic wait_idle();
    int c = 0;
    while ((busy_w[0] | busy_w[1] | busy_w[2]) && c < 30) begin
      @(negedge clk);
      c++;
    end
    chk("idle_timeout", 64'(busy_w[0] | busy_w[1] | busy_w[2]), 64'(0));
  endtask

  // One operation with a literal expected product and latency; a mid-operation start is injected.
  task automatic run_lit(input logic [23:0] av, input logic [23:0] bv,
                         input logic [47:0] lit, input string nm);
    bit seen [NL];
    for (int g = 0; g < NL; g++) seen[g] = 1'b0;
    wait_idle();
    a = av; b = bv; start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) begin start = 1'b0; a = 24'($urandom); b = 24'($urandom); end
      if (c == 3) start = 1'b1;
      if (c == 4) start = 1'b0;
      for (int g = 0; g < NL; g++) begin
        if (done_w[g] && !seen[g]) begin
          seen[g] = 1'b1;
          chk($sformatf("%s_prod_l%0d", nm, g), 64'(product_w[g]), 64'(lit));
          chk($sformatf("%s_lat_l%0d", nm, g), 64'(c), 64'(5 + lat_of(g)));
        end
      end
    end
    for (int g = 0; g < NL; g++) begin
      if (!seen[g]) chk($sformatf("%s_done_timeout_l%0d", nm, g), 64'(0), 64'(1));
    end
  endtask

  function automatic logic [23:0] pick();
    case ($urandom % 4)
      0:       return 24'h000000;
      1:       return 24'hFFFFFF;
      default: return 24'($urandom);
    endcase
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < NL; g++) begin
      chk($sformatf("rst_busy_l%0d", g),    64'(busy_w[g]),    64'(0));
      chk($sformatf("rst_product_l%0d", g), 64'(product_w[g]), 64'(0));
      chk($sformatf("rst_mul_a_l%0d", g),   64'(mul_a_w[g]),   64'(0));
    end
    rst = 1'b0;
    run_chk = 1'b1;

    run_lit(24'h800000, 24'h800000, 48'h400000000000, "half");
    run_lit(24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, "max");
    run_lit(24'h123456, 24'h00ABCD, 48'h000C37895ADE, "sweep");

    // start held high: accepts only when idle, back to back
    wait_idle();
    start = 1'b1;
    repeat (40) begin
      @(negedge clk);
      a = pick(); b = pick();
    end
    start = 1'b0;

    // randomized starts, including many while busy
    repeat (300) begin
      @(negedge clk);
      start = ($urandom % 4) == 0;
      a = pick(); b = pick();
    end
    start = 1'b0;

    // asynchronous reset during ISSUE aborts with immediate zero outputs
    wait_idle();
    a = 24'($urandom) | 24'h800001; b = 24'($urandom) | 24'h800001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    for (int g = 0; g < NL; g++) begin
      chk($sformatf("arst_busy_l%0d", g),    64'(busy_w[g]),    64'(0));
      chk($sformatf("arst_done_l%0d", g),    64'(done_w[g]),    64'(0));
      chk($sformatf("arst_product_l%0d", g), 64'(product_w[g]), 64'(0));
      chk($sformatf("arst_mul_a_l%0d", g),   64'(mul_a_w[g]),   64'(0));
      chk($sformatf("arst_mul_b_l%0d", g),   64'(mul_b_w[g]),   64'(0));
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);

    // zero operand, then product and multiplier operands hold through idle cycles
    run_lit(24'h000000, 24'hFFFFFF, 48'h0, "zero");
    repeat (20) @(negedge clk);
    for (int g = 0; g < NL; g++) begin
      chk($sformatf("hold_product_l%0d", g), 64'(product_w[g]), 64'(0));
      chk($sformatf("hold_mul_a_l%0d", g),   64'(mul_a_w[g]),   64'(0));
    end

    run_chk = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
